fp_regfile_sb: RTL and testbench

- Parametrised floating-point register file with an integrated busy-bit scoreboard.
- Serves the FP datapath: N combinational operand read ports, one store-data read port, and two write ports.
  - FPU writeback port for multi-cycle results.
  - Integer-to-FP move/convert port.
- Optional write-to-read bypass and NaN-boxing of single-precision results when FLEN > 32.
- Scoreboard flags operand hazards so decode can stall on pending multi-cycle FP results.

---
 rtl/fp_regfile_sb.sv | 138 +++++++++++++
 tb/tb_fp_regfile_sb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_regfile_sb.sv
// Floating-point register file with busy-bit scoreboard: NRD operand ports plus a store port,
// FPU writeback and integer-move write ports, optional write bypass and NaN-boxing.
module fp_regfile_sb #(
    parameter int unsigned  FLEN   = 32,
    parameter int unsigned  NREGS  = 32,
    parameter int unsigned  NRD    = 3,
    parameter int unsigned  BYPASS = 1,
    parameter int unsigned  NANBOX = 1,
    localparam int unsigned AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NRD*AW-1:0]   raddr_i,
    output logic [NRD*FLEN-1:0] rdata_o,
    output logic [NRD-1:0]      rbusy_o,
    input  logic [AW-1:0]       st_addr_i,
    output logic [FLEN-1:0]     st_data_o,
    input  logic                issue_en_i,
    input  logic [AW-1:0]       issue_rd_i,
    input  logic                wb_en_i,
    input  logic [AW-1:0]       wb_addr_i,
    input  logic [FLEN-1:0]     wb_data_i,
    input  logic                wb_sp_i,
    input  logic                mv_en_i,
    input  logic [AW-1:0]       mv_addr_i,
    input  logic [31:0]         mv_data_i,
    input  logic                flush_i,
    output logic                collision_o
);

    if (!(FLEN == 32 || FLEN == 64)) begin : g_bad_flen
        $error("fp_regfile_sb: FLEN must be 32 or 64");
    end
    if (NRD < 1 || NRD > 4) begin : g_bad_nrd
        $error("fp_regfile_sb: NRD must be in 1..4");
    end

    logic [FLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic             r_collision;

    logic             w_box;
    logic [63:0]      w_wb_wide;
    logic [63:0]      w_mv_wide;
    logic [FLEN-1:0]  w_wb_fmt;
    logic [FLEN-1:0]  w_mv_fmt;
    logic             w_same;
    logic             w_wb_we;
    logic [NREGS-1:0] w_busy_nxt;

    // Formatting is done at 64 bits and truncated so one path serves both FLEN values.
    always_comb begin
        w_box     = (FLEN == 64) && (NANBOX != 0);
        w_wb_wide = 64'(wb_data_i);
        if (w_box && wb_sp_i) begin
            w_wb_wide = {32'hFFFF_FFFF, w_wb_wide[31:0]};
        end
        w_mv_wide = w_box ? {32'hFFFF_FFFF, mv_data_i} : {32'h0, mv_data_i};
        w_wb_fmt  = FLEN'(w_wb_wide);
        w_mv_fmt  = FLEN'(w_mv_wide);
    end

    assign w_same  = wb_en_i && mv_en_i && (wb_addr_i == mv_addr_i);
    assign w_wb_we = wb_en_i && !w_same;

    // Order matters: wb clear, then issue set (new producer wins), then flush overrides all.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_en_i) begin
            w_busy_nxt[wb_addr_i] = 1'b0;
        end
        if (issue_en_i) begin
            w_busy_nxt[issue_rd_i] = 1'b1;
        end
        if (flush_i) begin
            w_busy_nxt = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy      <= '0;
            r_collision <= 1'b0;
        end else begin
            if (w_wb_we) begin
                r_regs[wb_addr_i] <= w_wb_fmt;
            end
            if (mv_en_i) begin
                r_regs[mv_addr_i] <= w_mv_fmt;
            end
            r_busy      <= w_busy_nxt;
            r_collision <= w_same;
        end
    end

    assign collision_o = r_collision;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [FLEN-1:0] w_data;
        logic            w_busy;

        assign w_addr = raddr_i[k*AW +: AW];

        always_comb begin
            w_data = r_regs[w_addr];
            w_busy = r_busy[w_addr];
            if (BYPASS != 0) begin
                if (mv_en_i && (mv_addr_i == w_addr)) begin
                    w_data = w_mv_fmt;
                end else if (wb_en_i && (wb_addr_i == w_addr)) begin
                    w_data = w_wb_fmt;
                end
                if (wb_en_i && (wb_addr_i == w_addr)) begin
                    w_busy = 1'b0;
                end
            end
        end

        assign rdata_o[k*FLEN +: FLEN] = w_data;
        assign rbusy_o[k]              = w_busy;
    end

    always_comb begin
        st_data_o = r_regs[st_addr_i];
        if (BYPASS != 0) begin
            if (mv_en_i && (mv_addr_i == st_addr_i)) begin
                st_data_o = w_mv_fmt;
            end else if (wb_en_i && (wb_addr_i == st_addr_i)) begin
                st_data_o = w_wb_fmt;
            end
        end
    end

endmodule

// File: tb/tb_fp_regfile_sb.sv
// Scoreboard bench for fp_regfile_sb: a bypassing and a non-bypassing instance (FLEN=64)
// share stimulus; a monitor pops expected outputs from a queue every cycle.
module tb_fp_regfile_sb;

    localparam int FLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 3;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*FLEN-1:0] rdata_b, rdata_n;
    logic [NRD-1:0]      rbusy_b, rbusy_n;
    logic [AW-1:0]       st_addr;
    logic [FLEN-1:0]     st_b, st_n;
    logic                issue_en;
    logic [AW-1:0]       issue_rd;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [FLEN-1:0]     wb_data;
    logic                wb_sp;
    logic                mv_en;
    logic [AW-1:0]       mv_addr;
    logic [31:0]         mv_data;
    logic                flush;
    logic                coll_b, coll_n;

    always #5 clk = ~clk;

    fp_regfile_sb #(.FLEN(FLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1), .NANBOX(1)) u_dut_byp (
        .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
        .st_addr_i(st_addr), .st_data_o(st_b), .issue_en_i(issue_en), .issue_rd_i(issue_rd),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_sp_i(wb_sp),
        .mv_en_i(mv_en), .mv_addr_i(mv_addr), .mv_data_i(mv_data), .flush_i(flush),
        .collision_o(coll_b)
    );

    fp_regfile_sb #(.FLEN(FLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0), .NANBOX(1)) u_dut_nob (
        .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata_n), .rbusy_o(rbusy_n),
        .st_addr_i(st_addr), .st_data_o(st_n), .issue_en_i(issue_en), .issue_rd_i(issue_rd),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_sp_i(wb_sp),
        .mv_en_i(mv_en), .mv_addr_i(mv_addr), .mv_data_i(mv_data), .flush_i(flush),
        .collision_o(coll_n)
    );

    typedef struct {
        logic [NRD*FLEN-1:0] rd_b, rd_n;
        logic [NRD-1:0]      rb_b, rb_n;
        logic [FLEN-1:0]     st_b, st_n;
        logic                coll;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Staged stimulus for the next cycle
    bit          n_rst;
    int          n_ra[NRD];
    int          n_st;
    bit          n_issue_en, n_wb_en, n_wb_sp, n_mv_en, n_flush;
    int          n_issue_rd, n_wb_addr, n_mv_addr;
    logic [63:0] n_wb_data;
    logic [31:0] n_mv_data;

    // Reference architectural state
    logic [63:0] m_reg[NREGS];
    bit          m_busy[NREGS];
    bit          m_coll;
    logic [63:0] m_fm, m_fw;

    function automatic logic [63:0] m_read(int a, bit byp);
        if (byp && n_mv_en && n_mv_addr == a) return m_fm;
        if (byp && n_wb_en && n_wb_addr == a) return m_fw;
        return m_reg[a];
    endfunction

    function automatic bit m_rbusy(int a, bit byp);
        return m_busy[a] && !(byp && n_wb_en && n_wb_addr == a);
    endfunction

    task automatic idle();
        n_rst = 0; n_issue_en = 0; n_wb_en = 0; n_mv_en = 0; n_flush = 0; n_wb_sp = 0;
    endtask

    task automatic step();
        exp_t e;
        bit   same;
        @(posedge clk);
        #2;
        rst      = n_rst;
        raddr    = {AW'(n_ra[2]), AW'(n_ra[1]), AW'(n_ra[0])};
        st_addr  = AW'(n_st);
        issue_en = n_issue_en; issue_rd = AW'(n_issue_rd);
        wb_en    = n_wb_en;    wb_addr  = AW'(n_wb_addr); wb_data = n_wb_data; wb_sp = n_wb_sp;
        mv_en    = n_mv_en;    mv_addr  = AW'(n_mv_addr); mv_data = n_mv_data;
        flush    = n_flush;

        m_fm = {32'hFFFF_FFFF, n_mv_data};
        m_fw = n_wb_sp ? {32'hFFFF_FFFF, n_wb_data[31:0]} : n_wb_data;
        if (n_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                m_reg[i] = '0; m_busy[i] = 0;
            end
            m_coll = 0;
        end
        for (int k = 0; k < NRD; k++) begin
            e.rd_b[k*FLEN +: FLEN] = m_read(n_ra[k], 1);
            e.rd_n[k*FLEN +: FLEN] = m_read(n_ra[k], 0);
            e.rb_b[k] = m_rbusy(n_ra[k], 1);
            e.rb_n[k] = m_rbusy(n_ra[k], 0);
        end
        e.st_b = m_read(n_st, 1);
        e.st_n = m_read(n_st, 0);
        e.coll = m_coll;
        q.push_back(e);

        if (!n_rst) begin
            same = n_wb_en && n_mv_en && (n_wb_addr == n_mv_addr);
            if (n_wb_en && !same) m_reg[n_wb_addr] = m_fw;
            if (n_mv_en) m_reg[n_mv_addr] = m_fm;
            if (n_wb_en) m_busy[n_wb_addr] = 0;
            if (n_issue_en) m_busy[n_issue_rd] = 1;
            if (n_flush) for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
            m_coll = same;
        end
    endtask

    task automatic chk(string name, logic [NRD*FLEN-1:0] act, logic [NRD*FLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rdata_byp", rdata_b, e.rd_b);
                chk("rdata_nobyp", rdata_n, e.rd_n);
                chk("rbusy_byp", (NRD*FLEN)'(rbusy_b), (NRD*FLEN)'(e.rb_b));
                chk("rbusy_nobyp", (NRD*FLEN)'(rbusy_n), (NRD*FLEN)'(e.rb_n));
                chk("st_byp", (NRD*FLEN)'(st_b), (NRD*FLEN)'(e.st_b));
                chk("st_nobyp", (NRD*FLEN)'(st_n), (NRD*FLEN)'(e.st_n));
                chk("coll_byp", (NRD*FLEN)'(coll_b), (NRD*FLEN)'(e.coll));
                chk("coll_nobyp", (NRD*FLEN)'(coll_n), (NRD*FLEN)'(e.coll));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        rst = 1'b1; raddr = '0; st_addr = '0; issue_en = 0; issue_rd = '0; wb_en = 0;
        wb_addr = '0; wb_data = '0; wb_sp = 0; mv_en = 0; mv_addr = '0; mv_data = '0; flush = 0;
        idle();
        n_ra = '{0, 0, 0}; n_st = 0; n_issue_rd = 0; n_wb_addr = 0; n_mv_addr = 0;
        n_wb_data = '0; n_mv_data = '0;

        n_rst = 1; step();
        idle(); step();

        // Populate state, then reset mid-operation
        n_wb_en = 1; n_wb_addr = 3; n_wb_data = 64'h3F80_0000; n_ra = '{3, 3, 3}; n_st = 3;
        n_issue_en = 1; n_issue_rd = 3; step();
        idle(); n_wb_en = 1; n_mv_en = 1; n_wb_addr = 9; n_mv_addr = 9;
        n_wb_data = 64'h1; n_mv_data = 32'h2; n_issue_en = 1; n_issue_rd = 12; n_ra = '{3, 9, 12};
        step();
        idle(); n_rst = 1; step();
        idle(); step();

        // Write/read latency with single-precision writeback
        n_wb_en = 1; n_wb_addr = 5; n_wb_sp = 1; n_wb_data = 64'h0000_0000_4049_0FDB;
        n_ra = '{5, 0, 0}; n_st = 5; step();
        idle(); step();

        // Scoreboard
        n_issue_en = 1; n_issue_rd = 7; n_ra = '{0, 7, 0}; step();
        idle(); step();
        n_wb_en = 1; n_wb_addr = 7; n_wb_data = 64'h0123_4567_89AB_CDEF; step();
        idle(); step();
        n_issue_en = 1; n_issue_rd = 7; n_wb_en = 1; n_wb_addr = 7; n_wb_data = 64'h55; step();
        idle(); step();

        // Collision
        n_wb_en = 1; n_wb_addr = 9; n_wb_data = 64'h1111_1111; n_mv_en = 1; n_mv_addr = 9;
        n_mv_data = 32'h2222_2222; n_ra = '{0, 0, 9}; n_st = 9; step();
        idle(); step();
        step();

        // NaN-boxing and double-precision passthrough
        n_mv_en = 1; n_mv_addr = 2; n_mv_data = 32'h3F80_0000; n_ra = '{2, 10, 0}; step();
        idle(); n_wb_en = 1; n_wb_addr = 10; n_wb_sp = 0; n_wb_data = 64'h4009_21FB_5444_2D18;
        n_st = 10; step();
        idle(); step();

        // Flush overrides a same-cycle issue
        n_issue_en = 1; n_issue_rd = 1; n_ra = '{1, 4, 6}; step();
        n_issue_rd = 4; step();
        n_issue_rd = 6; n_flush = 1; step();
        idle(); step();

        // Randomized traffic on a narrow address window to provoke hazards
        for (int c = 0; c < 500; c++) begin
            idle();
            for (int k = 0; k < NRD; k++) n_ra[k] = $urandom_range(0, 7);
            n_st       = $urandom_range(0, 7);
            n_issue_en = ($urandom_range(0, 2) == 0);
            n_issue_rd = $urandom_range(0, 7);
            n_wb_en    = ($urandom_range(0, 1) == 0);
            n_wb_addr  = $urandom_range(0, 7);
            n_wb_sp    = $urandom_range(0, 1);
            n_wb_data  = {$urandom, $urandom};
            n_mv_en    = ($urandom_range(0, 2) == 0);
            n_mv_addr  = $urandom_range(0, 7);
            n_mv_data  = $urandom;
            n_flush    = ($urandom_range(0, 24) == 0);
            n_rst      = ($urandom_range(0, 99) == 0);
            step();
        end

        idle(); step(); step();
        repeat (3) @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
